// File: rtl/main_mem_responder_if.sv
// Request/response bundle between the cache controller (master) and the
// main-memory responder (slave).
interface main_mem_responder_if #(
  parameter int DATA_WIDTH       = 32,
  parameter int OFFSET_WIDTH     = 4,
  parameter int BLOCK_ADDR_WIDTH = 26
);
  localparam int WORDS_PER_BLOCK = 1 << OFFSET_WIDTH;
  localparam int BLOCK_BITS      = DATA_WIDTH * WORDS_PER_BLOCK;

  logic                        req_valid;
  logic                        req_ready;
  logic                        req_write;
  logic [BLOCK_ADDR_WIDTH-1:0] req_block_addr;
  logic [BLOCK_BITS-1:0]       req_wdata;
  logic [WORDS_PER_BLOCK-1:0]  req_wmask;
  logic                        resp_valid;
  logic                        resp_ready;
  logic [BLOCK_BITS-1:0]       resp_rdata;
  logic                        resp_write;
  logic                        resp_err;
  logic                        busy;

  modport master (
    output req_valid, req_write, req_block_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_write, resp_err, busy
  );

  modport slave (
    input  req_valid, req_write, req_block_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_write, resp_err, busy
  );
endinterface

// File: rtl/main_mem_responder.sv
// Block-granular main-memory end-point: one outstanding block read or masked
// block write, fixed access latency, response held until taken.
//   state | meaning
//   IDLE  | ready for a request
//   BUSY  | latency countdown; access happens on the edge where cnt == 0
//   RESP  | response presented, waiting for resp_ready
module main_mem_responder #(
  parameter int DATA_WIDTH       = 32,
  parameter int OFFSET_WIDTH     = 4,
  parameter int BLOCK_ADDR_WIDTH = 26,
  parameter int MEM_BLOCKS       = 4096,
  parameter int LATENCY          = 4
) (
  input logic                clk,
  input logic                reset,
  main_mem_responder_if.slave bus
);
  localparam int WORDS_PER_BLOCK = 1 << OFFSET_WIDTH;
  localparam int BLOCK_BITS      = DATA_WIDTH * WORDS_PER_BLOCK;
  localparam int MEM_AW          = $clog2(MEM_BLOCKS);
  localparam logic [BLOCK_ADDR_WIDTH-1:0] MEM_LIMIT = BLOCK_ADDR_WIDTH'(MEM_BLOCKS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                      state, state_next;
  logic [7:0]                  cnt;
  logic                        lat_write;
  logic [BLOCK_ADDR_WIDTH-1:0] lat_addr;
  logic [BLOCK_BITS-1:0]       lat_wdata;
  logic [WORDS_PER_BLOCK-1:0]  lat_wmask;
  logic [BLOCK_BITS-1:0]       rdata_q;
  logic                        write_q;
  logic                        err_q;
  logic                        accept;
  logic                        access;
  logic                        in_range;
  logic [MEM_AW-1:0]           mem_idx;

  logic [DATA_WIDTH-1:0] mem [MEM_BLOCKS][WORDS_PER_BLOCK];

  assign in_range = lat_addr < MEM_LIMIT;
  assign mem_idx  = lat_addr[MEM_AW-1:0];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next     = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.busy       = 1'b1;
    accept         = 1'b0;
    access         = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        bus.busy      = 1'b0;
        if (bus.req_valid) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 8'd0) begin
          access     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= 8'd0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wmask <= '0;
      rdata_q   <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        lat_write <= bus.req_write;
        lat_addr  <= bus.req_block_addr;
        lat_wdata <= bus.req_wdata;
        lat_wmask <= bus.req_wmask;
        cnt       <= 8'(LATENCY - 1);
      end else if (state == BUSY && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
      if (access) begin
        write_q <= lat_write;
        err_q   <= !in_range;
        if (!lat_write && in_range) begin
          for (int i = 0; i < WORDS_PER_BLOCK; i++)
            rdata_q[i*DATA_WIDTH +: DATA_WIDTH] <= mem[mem_idx][i];
        end else begin
          rdata_q <= '0;
        end
      end
      if (state == RESP && bus.resp_ready) err_q <= 1'b0;
    end
  end

  // Array is deliberately not reset; a write still counting down when reset hits never commits.
  always_ff @(posedge clk) begin
    if (!reset && access && lat_write && in_range) begin
      for (int i = 0; i < WORDS_PER_BLOCK; i++)
        if (lat_wmask[i]) mem[mem_idx][i] <= lat_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_write = write_q;
  assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_main_mem_responder.sv
// Directed plus randomized bench for main_mem_responder against a block-level
// memory model.
module tb_main_mem_responder;
  localparam int DW         = 32;
  localparam int OW         = 4;
  localparam int WPB        = 1 << OW;
  localparam int BAW        = 26;
  localparam int MEM_BLOCKS = 4096;
  localparam int LATENCY    = 4;
  localparam int BB         = DW * WPB;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  main_mem_responder_if #(.DATA_WIDTH(DW), .OFFSET_WIDTH(OW), .BLOCK_ADDR_WIDTH(BAW)) bus ();

  main_mem_responder #(
    .DATA_WIDTH(DW), .OFFSET_WIDTH(OW), .BLOCK_ADDR_WIDTH(BAW),
    .MEM_BLOCKS(MEM_BLOCKS), .LATENCY(LATENCY)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [DW-1:0] ref_mem [MEM_BLOCKS][WPB];

  task automatic check(input string tag, input logic [BB-1:0] obs, input logic [BB-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic addr_ok(input logic [BAW-1:0] addr);
    return addr < BAW'(MEM_BLOCKS);
  endfunction

  function automatic logic [BB-1:0] model_rdata(input logic wr, input logic [BAW-1:0] addr);
    logic [BB-1:0] r;
    r = '0;
    if (!wr && addr_ok(addr))
      for (int i = 0; i < WPB; i++) r[i*DW +: DW] = ref_mem[addr[11:0]][i];
    return r;
  endfunction

  function automatic void model_apply(input logic wr, input logic [BAW-1:0] addr,
                                      input logic [BB-1:0] wdata, input logic [WPB-1:0] wmask);
    if (wr && addr_ok(addr))
      for (int i = 0; i < WPB; i++)
        if (wmask[i]) ref_mem[addr[11:0]][i] = wdata[i*DW +: DW];
  endfunction

  function automatic logic [BB-1:0] rand_block();
    logic [BB-1:0] b;
    for (int i = 0; i < WPB; i++) b[i*DW +: DW] = $urandom;
    return b;
  endfunction

  function automatic logic [BB-1:0] fill_block(input logic [DW-1:0] base, input logic step);
    logic [BB-1:0] b;
    for (int i = 0; i < WPB; i++) b[i*DW +: DW] = step ? base + DW'(i) : base;
    return b;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, " req_ready"}, bus.req_ready, 1);
    check({tag, " resp_valid"}, bus.resp_valid, 0);
    check({tag, " resp_write"}, bus.resp_write, 0);
    check({tag, " resp_err"}, bus.resp_err, 0);
    check({tag, " busy"}, bus.busy, 0);
    check({tag, " resp_rdata"}, bus.resp_rdata, 0);
  endtask

  // Entered and left at a negedge with the responder idle.
  task automatic run_req(input logic wr, input logic [BAW-1:0] addr, input logic [BB-1:0] wdata,
                         input logic [WPB-1:0] wmask, input int hold, input string tag);
    logic [BB-1:0] exp_data;
    int k;
    exp_data = model_rdata(wr, addr);
    bus.req_valid      = 1'b1;
    bus.req_write      = wr;
    bus.req_block_addr = addr;
    bus.req_wdata      = wdata;
    bus.req_wmask      = wmask;
    check({tag, " ready_before"}, bus.req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid      = 1'b0;
    bus.req_write      = ~wr;
    bus.req_block_addr = BAW'($urandom);
    bus.req_wdata      = rand_block();
    bus.req_wmask      = WPB'($urandom);
    k = 0;
    while (!bus.resp_valid && k < 40) begin
      check({tag, " busy_wait"}, {bus.busy, bus.req_ready}, 2'b10);
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, k, LATENCY);
    check({tag, " rdata"}, bus.resp_rdata, exp_data);
    check({tag, " write"}, bus.resp_write, wr);
    check({tag, " err"}, bus.resp_err, !addr_ok(addr));
    check({tag, " busy_resp"}, {bus.busy, bus.req_ready}, 2'b10);
    for (int h = 0; h < hold; h++) begin
      bus.req_valid = (h % 2 == 0);
      @(negedge clk);
      check({tag, " hold_valid"}, bus.resp_valid, 1);
      check({tag, " hold_rdata"}, bus.resp_rdata, exp_data);
      check({tag, " hold_write"}, bus.resp_write, wr);
      check({tag, " hold_ready"}, bus.req_ready, 0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check({tag, " after_hs"}, {bus.resp_valid, bus.resp_err, bus.busy, bus.req_ready}, 4'b0001);
    model_apply(wr, addr, wdata, wmask);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BB-1:0] blk;
    logic [BAW-1:0] a;
    int acc_edges[$];
    logic rdy_s;
    logic exp_busy;
    int a0, a1;

    reset              = 1'b1;
    bus.req_valid      = 1'b0;
    bus.req_write      = 1'b0;
    bus.req_block_addr = '0;
    bus.req_wdata      = '0;
    bus.req_wmask      = '0;
    bus.resp_ready     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);

    // Full write then read of block 5
    run_req(1'b1, 26'd5, fill_block(32'hA000_0000, 1'b1), 16'hFFFF, 0, "wr5");
    run_req(1'b0, 26'd5, '0, '0, 0, "rd5");
    blk = fill_block(32'hA000_0000, 1'b1);
    check("rd5 direct", bus.resp_rdata, blk);

    // Partial mask overwrite of block 7
    run_req(1'b1, 26'd7, fill_block(32'h1111_1111, 1'b0), 16'hFFFF, 0, "wr7a");
    run_req(1'b1, 26'd7, fill_block(32'h2222_2222, 1'b0), 16'h0003, 0, "wr7b");
    run_req(1'b0, 26'd7, '0, '0, 0, "rd7");
    check("rd7 word1", bus.resp_rdata[1*DW +: DW], 32'h2222_2222);
    check("rd7 word2", bus.resp_rdata[2*DW +: DW], 32'h1111_1111);

    // Out-of-range boundary, then in-range read is unaffected
    run_req(1'b0, 26'd4096, '0, '0, 0, "rd4096");
    run_req(1'b1, 26'd4096, rand_block(), 16'hFFFF, 0, "wr4096");
    run_req(1'b0, 26'h3FF_FFFF, '0, '0, 0, "rdmax");
    run_req(1'b0, 26'd5, '0, '0, 0, "rd5b");

    // Response held off for 10 cycles with stray request pulses
    run_req(1'b0, 26'd5, '0, '0, 10, "hold5");

    // Reset two cycles into a write of block 9 discards it
    run_req(1'b1, 26'd9, fill_block(32'h9000_0000, 1'b1), 16'hFFFF, 0, "wr9");
    bus.req_valid      = 1'b1;
    bus.req_write      = 1'b1;
    bus.req_block_addr = 26'd9;
    bus.req_wdata      = fill_block(32'hDEAD_BEEF, 1'b0);
    bus.req_wmask      = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("midreset");
    reset = 1'b0;
    run_req(1'b0, 26'd9, '0, '0, 0, "rd9");

    // Back-to-back reads with resp_ready held high
    a0 = 1;
    a1 = a0 + LATENCY + 2;
    blk = model_rdata(1'b0, 26'd5);
    bus.req_valid      = 1'b1;
    bus.req_write      = 1'b0;
    bus.req_block_addr = 26'd5;
    bus.resp_ready     = 1'b1;
    rdy_s = bus.req_ready;
    for (int t = 1; t <= a1 + LATENCY + 1; t++) begin
      @(posedge clk);
      if (rdy_s) acc_edges.push_back(t);
      @(negedge clk);
      exp_busy = (t >= a0 && t <= a0 + LATENCY) || (t >= a1 && t <= a1 + LATENCY);
      check($sformatf("b2b busy t%0d", t), {bus.busy, bus.req_ready}, {exp_busy, !exp_busy});
      check($sformatf("b2b valid t%0d", t), bus.resp_valid,
            (t == a0 + LATENCY) || (t == a1 + LATENCY));
      if (t == a0 + LATENCY || t == a1 + LATENCY)
        check($sformatf("b2b rdata t%0d", t), bus.resp_rdata, blk);
      rdy_s = bus.req_ready;
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    check("b2b accept_count", acc_edges.size(), 2);
    if (acc_edges.size() == 2) begin
      check("b2b first_accept", acc_edges[0], a0);
      check("b2b spacing", acc_edges[1] - acc_edges[0], LATENCY + 2);
    end
    @(negedge clk);

    // Randomized traffic over a small set of known blocks plus out-of-range ones
    for (int b = 0; b < 4; b++)
      run_req(1'b1, BAW'(b), rand_block(), 16'hFFFF, 0, $sformatf("init%0d", b));
    run_req(1'b1, 26'd4095, rand_block(), 16'hFFFF, 0, "init4095");
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = BAW'($urandom_range(0, 3));
        4:          a = 26'd5;
        5:          a = 26'd7;
        6:          a = 26'd9;
        7:          a = 26'd4095;
        8:          a = BAW'(4096 + $urandom_range(0, 100));
        default:    a = 26'h3FF_FFFF;
      endcase
      run_req(1'($urandom_range(0, 1)), a, rand_block(), WPB'($urandom), $urandom_range(0, 3),
              $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/main_mem_responder.md
Name: main_mem_responder

Overview:
- Block-granular main-memory responder on the memory side of the cache refill/write-back interface; the cache controller is the initiator.
- Accepts one block request at a time: a block read (refill) or a block write (write-back) with per-word write mask.
- Models a fixed access latency and holds the response until the initiator takes it.
- Replaces the cache's internal memory array with a handshaked memory end-point.

Parameters:
- DATA_WIDTH, 32, bits per word
- OFFSET_WIDTH, 4, log2 words per block
- WORDS_PER_BLOCK, 1 << OFFSET_WIDTH, words per block
- BLOCK_ADDR_WIDTH, 26, block address width (ADDRESS_WIDTH - OFFSET_WIDTH - byte offset)
- MEM_BLOCKS, 4096, number of implemented blocks
- LATENCY, 4, cycles from request acceptance to response valid; legal range 1..255

Ports:
- clk  input  1  clock; all logic on the rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  initiator presents a request
- req_ready  output  1  responder can accept a request
- req_write  input  1  1 = block write, 0 = block read
- req_block_addr  input  BLOCK_ADDR_WIDTH  block address
- req_wdata  input  DATA_WIDTH*WORDS_PER_BLOCK  write block; word i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_wmask  input  WORDS_PER_BLOCK  per-word write enable; ignored for reads
- resp_valid  output  1  response available
- resp_ready  input  1  initiator accepts the response
- resp_rdata  output  DATA_WIDTH*WORDS_PER_BLOCK  read block, same packing; all zero for writes and errors
- resp_write  output  1  echoes req_write of the completed request
- resp_err  output  1  request address was >= MEM_BLOCKS
- busy  output  1  request outstanding (state != IDLE)

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - State returns to IDLE.
  - req_ready = 1. resp_valid = 0. resp_write = 0. resp_err = 0. busy = 0. resp_rdata = 0.
  - Latency counter = 0. Latched request registers = 0.
  - Memory array contents are not reset; they keep their values through reset.
- Request acceptance:
  - A request is accepted on any edge where req_valid && req_ready.
  - On acceptance, latch write, block address, wdata and wmask; load counter with LATENCY-1; go to BUSY.
- States:
  - IDLE: req_ready = 1, busy = 0. Accept -> BUSY. No request -> stay in IDLE.
  - BUSY: req_ready = 0, busy = 1. Counter decrements each cycle.
    - When counter == 0, perform the access on that edge and go to RESP.
    - Write: for each word i with wmask[i] = 1, memory[addr][i] <= wdata word i. Words with wmask[i] = 0 are unchanged. resp_rdata <= 0.
    - Read: resp_rdata <= memory[addr] (full block).
    - Out-of-range address (addr >= MEM_BLOCKS): no memory update, resp_rdata <= 0, resp_err <= 1.
    - Also on that edge: resp_valid <= 1, resp_write <= latched write.
  - RESP: resp_valid = 1, req_ready = 0. resp_rdata, resp_write and resp_err stay stable until the response handshake.
    - On resp_ready: resp_valid <= 0, resp_err <= 0; go to IDLE.
- Latency:
  - Request accepted at edge N -> resp_valid high after edge N+LATENCY.
  - LATENCY = 1 gives one BUSY cycle.
- Throughput and simultaneous events:
  - No overlap. req_ready rises the cycle after the response handshake, so the minimum request-to-request spacing is LATENCY+2 cycles when resp_ready is held high.
  - req_valid asserted outside IDLE is ignored.
  - Request inputs may change after acceptance without effect.
- Read-after-write: a read issued after a write's response handshake returns the written data. Words left unmasked by the write return their old contents.
- Reset mid-operation:
  - Reset in BUSY aborts the request; a write not yet committed is discarded.
  - Reset in RESP drops the pending response.
  - The memory state left by a committed write persists.
- Width rules: the block address compare against MEM_BLOCKS is unsigned and full-width. Counter width is 8 bits.

Test Plan:
- Write 0xA000_0000+i to word i of block 5 with wmask=0xFFFF, then read block 5 -> resp_rdata word i = 0xA000_0000+i; resp_write=0, resp_err=0; resp_valid exactly LATENCY cycles after acceptance.
- Write block 7 all 0x1111_1111, then write 0x2222_2222 with wmask=0x0003, then read block 7 -> words 0-1 = 0x2222_2222, words 2-15 = 0x1111_1111.
- Read block addr 4096 (MEM_BLOCKS) -> resp_err=1, resp_rdata=0; a following read of block 5 returns unchanged data with resp_err=0.
- Hold resp_ready=0 for 10 cycles after resp_valid -> resp_valid, resp_rdata and resp_write stay stable, req_ready=0; req_valid pulses during this window are not accepted.
- Assert reset two cycles into a write to block 9 (LATENCY=4) -> all outputs take reset values the next cycle; a subsequent read of block 9 returns the pre-write contents.
- Back-to-back requests with resp_ready held high -> second acceptance occurs LATENCY+2 cycles after the first; busy is high exactly while each request is outstanding.
